// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state codes, default command bytes,
// frame geometry and a saturating counter helper.
package prog_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_A_HI    = 3'd1;
    localparam state_t ST_A_LO    = 3'd2;
    localparam state_t ST_D_HI    = 3'd3;
    localparam state_t ST_D_LO    = 3'd4;
    localparam state_t ST_WRITE   = 3'd5;
    localparam state_t ST_RST_CPU = 3'd6;
    localparam state_t ST_RUN     = 3'd7;

    localparam logic [7:0] DEF_CMD_INSTR = 8'hA1;
    localparam logic [7:0] DEF_CMD_DATA  = 8'hD1;
    localparam logic [7:0] DEF_CMD_RUN   = 8'h5A;

    // cmd byte followed by a big-endian 16-bit address and a 16-bit data word
    localparam int FRAME_LEN  = 5;
    localparam int WORD_LANES = (FRAME_LEN - 1) / 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream (valid/ready) feeding the program loader.
interface prog_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/ldr_word_assembler.sv
// Per-lane big-endian byte shifter; word_o shows the value each lane will hold
// after this cycle, so the final byte of a word is usable in the cycle it arrives.
module ldr_word_assembler
    import prog_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        clr,
    input  logic [WORD_LANES-1:0]       shift_en,
    input  logic [7:0]                  byte_i,
    output logic [WORD_LANES-1:0][15:0] word_o
);

    generate
        for (genvar gi = 0; gi < WORD_LANES; gi++) begin : g_lane
            logic [15:0] word_q;
            logic [15:0] word_d;

            always_comb begin
                word_d = word_q;
                if (shift_en[gi]) begin
                    word_d = {word_q[7:0], byte_i};
                end
            end

            always_ff @(posedge clk) begin
                if (clr) begin
                    word_q <= 16'h0000;
                end else begin
                    word_q <= word_d;
                end
            end

            assign word_o[gi] = word_d;
        end
    endgenerate

endmodule

// File: rtl/prog_loader.sv
// Program loader for Single_Cycle_RISC: parses write/run frames from a byte stream,
// drives the CPU external memory write ports, then resets and releases the CPU.
// Optional build macro PROG_LOADER_CSUM_EN adds csum = XOR of all accepted bytes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         CLR_CYCLES = 2,
    parameter logic [7:0] CMD_INSTR  = DEF_CMD_INSTR,
    parameter logic [7:0] CMD_DATA   = DEF_CMD_DATA,
    parameter logic [7:0] CMD_RUN    = DEF_CMD_RUN
) (
    input  logic               clk,
    input  logic               clr,
    prog_loader_if.slave       stream,
    input  logic               cpu_halt,
    output logic               test_normal,
    output logic               ext_instr_we,
    output logic [15:0]        ext_instr_addr,
    output logic [15:0]        ext_instr_data,
    output logic               ext_data_we,
    output logic [15:0]        ext_data_addr,
    output logic [15:0]        ext_data_data,
    output logic               cpu_clr,
    output logic               busy,
    output logic               err,
    output logic [15:0]        words_loaded
`ifdef PROG_LOADER_CSUM_EN
    ,
    output logic [7:0]         csum
`endif
);

    localparam int CNT_W = (CLR_CYCLES < 2) ? 1 : $clog2(CLR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_CYCLES - 1);

    state_t           state_q, state_d;
    logic             sel_data_q, sel_data_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             run_first_q, run_first_d;
    logic             test_normal_q, test_normal_d;
    logic             cpu_clr_q, cpu_clr_d;
    logic             instr_we_q, instr_we_d;
    logic             data_we_q, data_we_d;
    logic [15:0]      instr_addr_q, instr_addr_d;
    logic [15:0]      instr_data_q, instr_data_d;
    logic [15:0]      data_addr_q, data_addr_d;
    logic [15:0]      data_data_q, data_data_d;
    logic             err_q, err_d;
    logic [15:0]      words_q, words_d;

    logic                        ready;
    logic                        accept;
    logic [WORD_LANES-1:0]       shift_en;
    logic [WORD_LANES-1:0][15:0] words_asm;

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_A_HI) || (state_q == ST_A_LO) ||
                    (state_q == ST_D_HI) || (state_q == ST_D_LO);
    assign accept = stream.in_valid & ready;

    // lane 0 collects the address, lane 1 the data word
    assign shift_en[0] = accept & ((state_q == ST_A_HI) || (state_q == ST_A_LO));
    assign shift_en[1] = accept & ((state_q == ST_D_HI) || (state_q == ST_D_LO));

    ldr_word_assembler u_asm (
        .clk      (clk),
        .clr      (clr),
        .shift_en (shift_en),
        .byte_i   (stream.in_byte),
        .word_o   (words_asm)
    );

    always_comb begin
        state_d       = state_q;
        sel_data_d    = sel_data_q;
        clr_cnt_d     = clr_cnt_q;
        run_first_d   = run_first_q;
        test_normal_d = test_normal_q;
        cpu_clr_d     = cpu_clr_q;
        instr_we_d    = 1'b0;
        data_we_d     = 1'b0;
        instr_addr_d  = instr_addr_q;
        instr_data_d  = instr_data_q;
        data_addr_d   = data_addr_q;
        data_data_d   = data_data_q;
        err_d         = err_q;
        words_d       = words_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (stream.in_byte == CMD_INSTR || stream.in_byte == CMD_DATA) begin
                        state_d       = ST_A_HI;
                        sel_data_d    = (stream.in_byte == CMD_DATA);
                        test_normal_d = 1'b1;
                    end else if (stream.in_byte == CMD_RUN) begin
                        state_d       = ST_RST_CPU;
                        clr_cnt_d     = '0;
                        cpu_clr_d     = 1'b1;
                        test_normal_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_A_HI: if (accept) state_d = ST_A_LO;
            ST_A_LO: if (accept) state_d = ST_D_HI;
            ST_D_HI: if (accept) state_d = ST_D_LO;
            ST_D_LO: begin
                // strobe and output words are registered together so they appear as one cycle
                if (accept) begin
                    state_d = ST_WRITE;
                    words_d = sat_inc16(words_q);
                    if (sel_data_q) begin
                        data_we_d   = 1'b1;
                        data_addr_d = words_asm[0];
                        data_data_d = words_asm[1];
                    end else begin
                        instr_we_d   = 1'b1;
                        instr_addr_d = words_asm[0];
                        instr_data_d = words_asm[1];
                    end
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_RST_CPU: begin
                if (clr_cnt_q == CNT_LAST) begin
                    state_d     = ST_RUN;
                    cpu_clr_d   = 1'b0;
                    run_first_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // the halt flag may still be high from the previous program on the first cycle
                run_first_d = 1'b0;
                if (!run_first_q && cpu_halt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            sel_data_q    <= 1'b0;
            clr_cnt_q     <= '0;
            run_first_q   <= 1'b0;
            test_normal_q <= 1'b1;
            cpu_clr_q     <= 1'b0;
            instr_we_q    <= 1'b0;
            data_we_q     <= 1'b0;
            instr_addr_q  <= 16'h0000;
            instr_data_q  <= 16'h0000;
            data_addr_q   <= 16'h0000;
            data_data_q   <= 16'h0000;
            err_q         <= 1'b0;
            words_q       <= 16'h0000;
        end else begin
            state_q       <= state_d;
            sel_data_q    <= sel_data_d;
            clr_cnt_q     <= clr_cnt_d;
            run_first_q   <= run_first_d;
            test_normal_q <= test_normal_d;
            cpu_clr_q     <= cpu_clr_d;
            instr_we_q    <= instr_we_d;
            data_we_q     <= data_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_data_q  <= instr_data_d;
            data_addr_q   <= data_addr_d;
            data_data_q   <= data_data_d;
            err_q         <= err_d;
            words_q       <= words_d;
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = csum_q ^ stream.in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

    assign stream.in_ready = ready;
    assign test_normal     = test_normal_q;
    assign cpu_clr         = cpu_clr_q;
    assign ext_instr_we    = instr_we_q;
    assign ext_instr_addr  = instr_addr_q;
    assign ext_instr_data  = instr_data_q;
    assign ext_data_we     = data_we_q;
    assign ext_data_addr   = data_addr_q;
    assign ext_data_data   = data_data_q;
    assign busy            = (state_q != ST_IDLE);
    assign err             = err_q;
    assign words_loaded    = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised scoreboard bench for prog_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares each write strobe the loader issues.
module tb_prog_loader;

    localparam int CLR_CYCLES = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        cpu_halt;
    logic        test_normal;
    logic        ext_instr_we;
    logic [15:0] ext_instr_addr;
    logic [15:0] ext_instr_data;
    logic        ext_data_we;
    logic [15:0] ext_data_addr;
    logic [15:0] ext_data_data;
    logic        cpu_clr;
    logic        busy;
    logic        err;
    logic [15:0] words_loaded;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]  csum;
`endif

    prog_loader_if stream ();

    prog_loader #(.CLR_CYCLES(CLR_CYCLES)) dut (
        .clk            (clk),
        .clr            (clr),
        .stream         (stream),
        .cpu_halt       (cpu_halt),
        .test_normal    (test_normal),
        .ext_instr_we   (ext_instr_we),
        .ext_instr_addr (ext_instr_addr),
        .ext_instr_data (ext_instr_data),
        .ext_data_we    (ext_data_we),
        .ext_data_addr  (ext_data_addr),
        .ext_data_data  (ext_data_data),
        .cpu_clr        (cpu_clr),
        .busy           (busy),
        .err            (err),
        .words_loaded   (words_loaded)
`ifdef PROG_LOADER_CSUM_EN
        ,
        .csum           (csum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_words = 0;
    bit          exp_err = 1'b0;
    bit          exp_tn = 1'b1;
    logic [7:0]  exp_csum = 8'h00;
    logic [15:0] last_iaddr = 16'h0, last_idata = 16'h0, last_daddr = 16'h0, last_ddata = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (!clr && (ext_instr_we || ext_data_we)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: instr_we=%b data_we=%b with no frame pending",
                         ext_instr_we, ext_data_we);
            end else begin
                wr_t e;
                bit  got_data;
                logic [15:0] a, d;
                e = exp_q.pop_front();
                got_data = ext_data_we;
                a = got_data ? ext_data_addr : ext_instr_addr;
                d = got_data ? ext_data_data : ext_instr_data;
                if ((ext_instr_we && ext_data_we) || got_data != e.is_data ||
                    a !== e.addr || d !== e.data || stream.in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL write: got iwe=%b dwe=%b addr=%h data=%h rdy=%b expected %s addr=%h data=%h rdy=0",
                             ext_instr_we, ext_data_we, a, d, stream.in_ready,
                             e.is_data ? "data" : "instr", e.addr, e.data);
                end else begin
                    $display("write %s addr=%h data=%h ok", got_data ? "data " : "instr", a, d);
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        stream.in_valid = 1'b0;
        stream.in_byte  = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        stream.in_valid = 1'b1;
        stream.in_byte  = b;
        while (!stream.in_ready) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", guard);
                $fatal(1, "loader stalled");
            end
        end
        @(posedge clk);
        #1;
        stream.in_valid = 1'b0;
        exp_csum ^= b;
    endtask

    task automatic send_frame(input bit is_data, input logic [15:0] a, input logic [15:0] d, input bit gaps);
        logic [7:0] bytes [5];
        wr_t e;
        bytes[0] = is_data ? 8'hD1 : 8'hA1;
        bytes[1] = a[15:8];
        bytes[2] = a[7:0];
        bytes[3] = d[15:8];
        bytes[4] = d[7:0];
        e.is_data = is_data;
        e.addr    = a;
        e.data    = d;
        exp_q.push_back(e);
        for (int i = 0; i < 5; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            send_byte(bytes[i]);
        end
        exp_words++;
        exp_tn = 1'b1;
        if (is_data) begin
            last_daddr = a;
            last_ddata = d;
        end else begin
            last_iaddr = a;
            last_idata = d;
        end
    endtask

    // Run the CPU: halt goes high from cycle h after the RUN byte. The loader may only leave
    // after CLR_CYCLES reset cycles plus one ignored RUN cycle, so busy lasts max(CLR_CYCLES+2, h).
    task automatic run_cpu(input int h, input string tag);
        int n_busy, n_clr, n_tn, exp_busy;
        n_busy = 0;
        n_clr  = 0;
        n_tn   = 0;
        exp_busy = (h > CLR_CYCLES + 2) ? h : CLR_CYCLES + 2;
        send_byte(8'h5A);
        for (int i = 1; i <= 200; i++) begin
            cpu_halt = (i >= h);
            @(negedge clk);
            if (!busy) break;
            n_busy++;
            if (cpu_clr) n_clr++;
            if (test_normal) n_tn++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cpu_halt = 1'b0;
        exp_tn = 1'b0;
        chk({tag, "_busy_cycles"}, n_busy, exp_busy);
        chk({tag, "_cpu_clr_cycles"}, n_clr, CLR_CYCLES);
        chk({tag, "_test_normal_high_cycles"}, n_tn, 0);
        chk({tag, "_idle_after_halt"}, {busy, stream.in_ready}, 2'b01);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_words_loaded"}, words_loaded, exp_words);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_test_normal"}, test_normal, exp_tn);
        chk({tag, "_instr_hold"}, {ext_instr_addr, ext_instr_data}, {last_iaddr, last_idata});
        chk({tag, "_data_hold"}, {ext_data_addr, ext_data_data}, {last_daddr, last_ddata});
`ifdef PROG_LOADER_CSUM_EN
        chk({tag, "_csum"}, csum, exp_csum);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_test_normal"}, test_normal, 1);
        chk({tag, "_cpu_clr"}, cpu_clr, 0);
        chk({tag, "_we"}, {ext_instr_we, ext_data_we}, 2'b00);
        chk({tag, "_instr_addr_data"}, {ext_instr_addr, ext_instr_data}, 32'h0);
        chk({tag, "_data_addr_data"}, {ext_data_addr, ext_data_data}, 32'h0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
        chk({tag, "_in_ready"}, stream.in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_words = 0;
        exp_err = 1'b0;
        exp_tn = 1'b1;
        exp_csum = 8'h00;
        last_iaddr = 16'h0;
        last_idata = 16'h0;
        last_daddr = 16'h0;
        last_ddata = 16'h0;
    endtask

    initial begin
        clr = 1'b1;
        cpu_halt = 1'b0;
        stream.in_valid = 1'b0;
        stream.in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check_reset_state("reset");

        // directed instruction and data frames
        send_frame(1'b0, 16'h0003, 16'hE000, 1'b0);
        idle_cycles(2);
        check_model("instr_frame");
        send_frame(1'b1, 16'h0025, 16'h0047, 1'b0);
        idle_cycles(2);
        check_model("data_frame");

        // run with halt already high: must still wait out reset and the first RUN cycle
        run_cpu(1, "run");
        check_model("after_run");

        // unknown command byte, then a frame still loads and re-enters load mode
        send_byte(8'h77);
        exp_err = 1'b1;
        idle_cycles(2);
        chk("bad_cmd_err", err, 1);
        chk("bad_cmd_idle", busy, 0);
        send_frame(1'b0, 16'h1234, 16'hBEEF, 1'b0);
        idle_cycles(2);
        check_model("after_bad_cmd");

        // reset in the middle of a frame
        send_byte(8'hA1);
        send_byte(8'h00);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        reset_model();
        check_reset_state("mid_frame_reset");
        send_frame(1'b0, 16'h0001, 16'h1234, 1'b0);
        idle_cycles(2);
        check_model("after_mid_reset");
`ifdef PROG_LOADER_CSUM_EN
        chk("csum_directed", csum, 8'h86);
`endif

        // randomised mix of frames (payload may contain command bytes), bad bytes and runs
        for (int it = 0; it < 80; it++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 75) begin
                logic [15:0] a, d;
                a = 16'($urandom);
                d = 16'($urandom);
                if ($urandom_range(0, 4) == 0) d[15:8] = 8'h5A;
                send_frame($urandom_range(0, 1) == 1, a, d, 1'b1);
            end else if (sel < 83) begin
                logic [7:0] b;
                b = 8'($urandom);
                while (b == 8'hA1 || b == 8'hD1 || b == 8'h5A) b = 8'($urandom);
                send_byte(b);
                exp_err = 1'b1;
            end else if (sel < 93) begin
                run_cpu($urandom_range(0, 8), "rand_run");
            end else begin
                idle_cycles($urandom_range(1, 4));
            end
        end
        idle_cycles(3);
        check_model("final");
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule
